// File: rtl/preamble_detector.sv
// preamble_detector: hunts for the (5k+3) mod 16 preamble, locks, then forwards a fixed-length payload.
// Define PREAMBLE_ERR_TOL_EN to tolerate up to MAX_ERR preamble mismatches and report err_count.
module preamble_detector #(
   parameter int ADDR_WIDTH  = 11,
   parameter int PRE_LEN     = 64,
   parameter int PAYLOAD_LEN = 512,
   parameter int MAX_ERR     = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  mod_switch,
   input  logic                  valid_in,
   input  logic [3:0]            data_in,
   output logic                  ready_out,
   output logic [3:0]            data_out,
   output logic                  data_valid,
   output logic                  sop,
   output logic                  eop,
   output logic                  lock,
   output logic [ADDR_WIDTH-1:0] err_count
);
   typedef enum logic [1:0] {HUNT, CHECK, PAYLOAD} state_t;
   localparam logic [ADDR_WIDTH-1:0] K_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(PRE_LEN - 1);
   localparam logic [ADDR_WIDTH-1:0] P_LAST = ADDR_WIDTH'(PAYLOAD_LEN - 1);
   if (MAX_ERR >= PRE_LEN || PRE_LEN > 2**ADDR_WIDTH || PAYLOAD_LEN > 2**ADDR_WIDTH) begin : g_bad_cfg
      $error("preamble_detector: inconsistent parameters");
   end
   // 5k mod 16 only depends on the low nibble of k
   function automatic logic [3:0] pat(input logic [3:0] k, input logic m);
      logic [3:0] v;
      v = k * 4'd5 + 4'd3;
      return v ^ {4{m}};
   endfunction
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] k_q, k_d, pidx_q, pidx_d;
   logic                  ms_q, ms_d;
   logic [3:0]            dout_q, dout_d;
   logic                  dv_q, dv_d, sop_q, sop_d, eop_q, eop_d, lock_q, lock_d;
   logic                  acc, hit0, miss, abort, last;
`ifdef PREAMBLE_ERR_TOL_EN
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, errc_q, errc_d, cnt_nx;
   assign cnt_nx    = cnt_q + ADDR_WIDTH'(miss);
   assign abort     = miss && (cnt_q == ADDR_WIDTH'(MAX_ERR));
   assign err_count = errc_q;
`else
   assign abort     = miss;
   assign err_count = '0;
`endif
   assign acc        = valid_in && enable;
   assign hit0       = data_in == pat(4'd0, mod_switch);
   assign miss       = data_in != pat(k_q[3:0], ms_q);
   assign last       = pidx_q == P_LAST;
   assign ready_out  = enable;
   assign data_out   = dout_q;
   assign data_valid = dv_q;
   assign sop        = sop_q;
   assign eop        = eop_q;
   assign lock       = lock_q;
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      pidx_d  = pidx_q;
      ms_d    = ms_q;
      dout_d  = dout_q;
      dv_d    = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      lock_d  = lock_q;
`ifdef PREAMBLE_ERR_TOL_EN
      cnt_d   = cnt_q;
      errc_d  = errc_q;
`endif
      if (acc && state_q == HUNT) begin
         if (hit0) begin
            state_d = CHECK;
            ms_d    = mod_switch;
            k_d     = K_ONE;
`ifdef PREAMBLE_ERR_TOL_EN
            cnt_d   = '0;
`endif
         end
      end else if (acc && state_q == CHECK) begin
         if (abort) begin
            // the aborting nibble may itself be the start of a new preamble
            state_d = hit0 ? CHECK : HUNT;
            ms_d    = hit0 ? mod_switch : ms_q;
            k_d     = hit0 ? K_ONE : '0;
`ifdef PREAMBLE_ERR_TOL_EN
            cnt_d   = '0;
`endif
         end else if (k_q == K_LAST) begin
            state_d = PAYLOAD;
            lock_d  = 1'b1;
            k_d     = '0;
            pidx_d  = '0;
`ifdef PREAMBLE_ERR_TOL_EN
            errc_d  = cnt_nx;
            cnt_d   = '0;
`endif
         end else begin
            k_d     = k_q + K_ONE;
`ifdef PREAMBLE_ERR_TOL_EN
            cnt_d   = cnt_nx;
`endif
         end
      end else if (acc && state_q == PAYLOAD) begin
         dout_d  = data_in;
         dv_d    = 1'b1;
         sop_d   = pidx_q == '0;
         eop_d   = last;
         state_d = last ? HUNT : PAYLOAD;
         lock_d  = !last;
         pidx_d  = last ? '0 : pidx_q + K_ONE;
      end
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= HUNT;
         k_q     <= '0;
         pidx_q  <= '0;
         ms_q    <= 1'b0;
         dout_q  <= '0;
         dv_q    <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         lock_q  <= 1'b0;
`ifdef PREAMBLE_ERR_TOL_EN
         cnt_q   <= '0;
         errc_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         pidx_q  <= pidx_d;
         ms_q    <= ms_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         lock_q  <= lock_d;
`ifdef PREAMBLE_ERR_TOL_EN
         cnt_q   <= cnt_d;
         errc_q  <= errc_d;
`endif
      end
   end
endmodule
